// File: rtl/alu_stage_pkg.sv
// Shared types for the ALU result stage: FSM state encoding and the held-entry layout.
package alu_stage_pkg;

  localparam int ALU_W     = 32;
  // Upper bound on TAG_W. Narrower tags are zero-extended into the entry.
  localparam int TAG_MAX_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ALU_W-1:0]     result;
    logic                 zero;
    logic                 cout;
    logic                 overflow;
    logic [TAG_MAX_W-1:0] tag;
  } entry_t;

endpackage

// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry registered skid buffer with optional sticky ovf/cout flags (ALU_STICKY_FLAGS_EN).
// Latency: 1 cycle from push to out_valid when empty; head stays stable while out_valid & ~out_ready.
// Backpressure: in_ready drops once both entries are held; in_valid is ignored while FULL.
module alu_result_stage
  import alu_stage_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ALU_W-1:0]  in_result,
  input  logic              in_zero,
  input  logic              in_cout,
  input  logic              in_overflow,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ALU_W-1:0]  out_result,
  output logic              out_zero,
  output logic              out_cout,
  output logic              out_overflow,
  output logic [TAG_W-1:0]  out_tag,
  input  logic              clr_sticky,
  output logic              sticky_ovf,
  output logic              sticky_cout
);

  state_t state;
  entry_t head;
  entry_t tail;
  entry_t in_ent;
  logic   out_valid_q;
  logic   in_ready_q;
  logic   push;
  logic   pop;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  always_comb begin
    in_ent          = '0;
    in_ent.result   = in_result;
    in_ent.zero     = in_zero;
    in_ent.cout     = in_cout;
    in_ent.overflow = in_overflow;
    in_ent.tag      = TAG_MAX_W'(in_tag);
  end

  // Handshake outputs are flops updated alongside the state, not decoded from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      head        <= '0;
      tail        <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head        <= in_ent;
            state       <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            head <= in_ent;
          end else if (push) begin
            tail       <= in_ent;
            state      <= FULL;
            in_ready_q <= 1'b0;
          end else if (pop) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (pop) begin
            head       <= tail;
            state      <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign out_valid    = out_valid_q;
  assign in_ready     = in_ready_q;
  assign out_result   = head.result;
  assign out_zero     = head.zero;
  assign out_cout     = head.cout;
  assign out_overflow = head.overflow;
  assign out_tag      = TAG_W'(head.tag);

  // Tag bits above TAG_W are always zero.
  logic unused_tag_hi;
  assign unused_tag_hi = ^head.tag;

`ifdef ALU_STICKY_FLAGS_EN
  logic sticky_ovf_q;
  logic sticky_cout_q;

  // A setting push wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf_q  <= 1'b0;
      sticky_cout_q <= 1'b0;
    end else begin
      if (push && in_overflow) sticky_ovf_q <= 1'b1;
      else if (clr_sticky)     sticky_ovf_q <= 1'b0;
      if (push && in_cout)     sticky_cout_q <= 1'b1;
      else if (clr_sticky)     sticky_cout_q <= 1'b0;
    end
  end

  assign sticky_ovf  = sticky_ovf_q;
  assign sticky_cout = sticky_cout_q;
`else
  logic unused_clr;
  assign unused_clr  = clr_sticky;
  assign sticky_ovf  = 1'b0;
  assign sticky_cout = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage; sticky expectations follow ALU_STICKY_FLAGS_EN.
module tb_alu_result_stage;

`ifdef ALU_STICKY_FLAGS_EN
  localparam logic STICKY_EN = 1'b1;
`else
  localparam logic STICKY_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_result = '0;
  logic        in_zero = 1'b0;
  logic        in_cout = 1'b0;
  logic        in_overflow = 1'b0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_cout;
  logic        out_overflow;
  logic [4:0]  out_tag;
  logic        clr_sticky = 1'b0;
  logic        sticky_ovf;
  logic        sticky_cout;

  int n_total = 0;
  int n_pass  = 0;

  alu_result_stage #(.TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_zero(in_zero), .in_cout(in_cout),
    .in_overflow(in_overflow), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_cout(out_cout),
    .out_overflow(out_overflow), .out_tag(out_tag),
    .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf), .sticky_cout(sticky_cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] t,
                       input logic z, input logic c, input logic o);
    in_valid = v; in_result = r; in_tag = t;
    in_zero = z; in_cout = c; in_overflow = o;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_result", out_result, 0);
    check("rst_out_zero", out_zero, 0);
    check("rst_out_cout", out_cout, 0);
    check("rst_out_ovf", out_overflow, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_sticky_ovf", sticky_ovf, 0);
    check("rst_sticky_cout", sticky_cout, 0);
    step();
    step();
    rst_n = 1'b1;

    // Single beat through an empty stage, accepted on the first edge after reset.
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_0005, 5'd3, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("single_valid", out_valid, 1);
    check("single_result", out_result, 32'h5);
    check("single_tag", out_tag, 3);
    step();
    check("single_drained", out_valid, 0);

    // Fill under backpressure; third beat must be refused.
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 5'd1, 1'b0, 1'b0, 1'b0);
    step();
    check("fill_ready_one", in_ready, 1);
    drive(1'b1, 32'hB, 5'd2, 1'b0, 1'b0, 1'b0);
    step();
    check("fill_ready_full", in_ready, 0);
    drive(1'b1, 32'hC, 5'd4, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("full_head_stable", out_result, 32'hA);
    check("full_head_tag", out_tag, 1);
    out_ready = 1'b1;
    step();
    check("drain_b_valid", out_valid, 1);
    check("drain_b_result", out_result, 32'hB);
    check("drain_b_tag", out_tag, 2);
    check("drain_b_ready", in_ready, 1);
    step();
    check("drain_empty", out_valid, 0);

    // Simultaneous push and pop in ONE replaces the head.
    out_ready = 1'b0;
    drive(1'b1, 32'h1, 5'd5, 1'b0, 1'b0, 1'b0);
    step();
    check("one_head", out_result, 32'h1);
    out_ready = 1'b1;
    drive(1'b1, 32'h2, 5'd6, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("pp_result", out_result, 32'h2);
    check("pp_tag", out_tag, 6);
    check("pp_valid", out_valid, 1);
    check("pp_ready", in_ready, 1);
    step();
    check("pp_drained", out_valid, 0);

    // Sticky overflow: set beats clear in the same cycle, then clear alone.
    drive(1'b1, 32'h7, 5'd7, 1'b0, 1'b0, 1'b1);
    clr_sticky = 1'b1;
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("stk_ovf_set", sticky_ovf, STICKY_EN);
    check("stk_out_ovf", out_overflow, 1);
    step();
    clr_sticky = 1'b0;
    check("stk_ovf_clr", sticky_ovf, 0);

    // Zero/carry flags carried through and accumulated.
    drive(1'b1, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("flg_zero", out_zero, 1);
    check("flg_cout", out_cout, 1);
    check("flg_result", out_result, 0);
    check("flg_sticky_cout", sticky_cout, STICKY_EN);
    check("flg_sticky_ovf", sticky_ovf, 0);
    step();

    // Asynchronous reset while FULL discards both entries.
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 5'd9, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h22, 5'd10, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("pre_rst_full", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_out_result", out_result, 0);
    check("arst_sticky_cout", sticky_cout, 0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("post_rst_empty", out_valid, 0);
    step();
    check("post_rst_still_empty", out_valid, 0);
    drive(1'b1, 32'h33, 5'd11, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("post_rst_new_valid", out_valid, 1);
    check("post_rst_new_result", out_result, 32'h33);
    step();
    check("post_rst_drained", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
